ahb_sram_slave_param: RTL
=========================

AHB_SRAM_SLAVE_PARAM -- requirements
Module: ahb_sram_slave_param

Interface
REQ-001 SHALL take parameter DATA_W, default 32, meaning the data bus width in bits; legal values are 32 and 64.
REQ-002 SHALL take parameter ADDR_W, default 31, meaning the haddr width.
REQ-003 SHALL take parameter DEPTH, default 1024, meaning the number of DATA_W-bit words; must be a power of 2.
REQ-004 SHALL take parameter WAIT_STATES, default 0, meaning the extra data-phase cycles per OKAY transfer; legal range 0..7.
REQ-005 SHALL take parameters ERR_BASE and ERR_MASK, defaults 0 and 0, meaning the error region; ERR_MASK=0 disables the region.
REQ-006 SHALL have port clock, input, width 1: the single clock; all state is on its rising edge.
REQ-007 SHALL have port reset, input, width 1: asynchronous, active-low reset.
REQ-008 SHALL have port io_ahb_hsel, input, width 1: slave select.
REQ-009 SHALL have port io_ahb_hready, input, width 1: bus hready (address-phase qualifier).
REQ-010 SHALL have port io_ahb_htrans, input, width 2: IDLE/BUSY/NONSEQ/SEQ.
REQ-011 SHALL have port io_ahb_hsize, input, width 3: transfer size.
REQ-012 SHALL have port io_ahb_hwrite, input, width 1: write when high.
REQ-013 SHALL have port io_ahb_haddr, input, width ADDR_W: byte address.
REQ-014 SHALL have port io_ahb_hwdata, input, width DATA_W: write data (data phase).
REQ-015 SHALL have ports io_ahb_hmastlock (1), io_ahb_hburst (3) and io_ahb_hprot (4), all inputs; they are accepted and ignored.
REQ-016 SHALL have port io_ahb_hreadyout, output, width 1: slave ready.
REQ-017 SHALL have port io_ahb_hresp, output, width 1: 0 = OKAY, 1 = ERROR.
REQ-018 SHALL have port io_ahb_hrdata, output, width DATA_W: read data.

Function
REQ-019 SHALL accept an address phase only when hsel=1, hready=1 and htrans[1]=1; it then registers haddr, hsize and hwrite.
REQ-020 SHALL give IDLE, BUSY or unselected cycles a zero-wait OKAY response (hreadyout=1, hresp=0) with no state change.
REQ-021 SHALL implement an FSM with states IDLE, DATA, WAIT, ERR1 and ERR2.
  - IDLE -> DATA on an accepted OKAY-class transfer.
  - IDLE -> ERR1 on an accepted error-class transfer.
REQ-022 SHALL classify a transfer as error-class if any of the following holds:
  - (haddr & ERR_MASK) == ERR_BASE with ERR_MASK != 0;
  - haddr is not aligned to 2^hsize bytes;
  - 2^hsize > DATA_W/8.
REQ-023 SHALL handle the DATA/WAIT states as follows:
  - A WAIT_STATES down-counter loads on acceptance.
  - hreadyout=0 while the counter is nonzero (WAIT), decrementing each cycle.
  - hreadyout=1 in the final data-phase cycle.
  - WAIT_STATES=0 gives a single-cycle data phase.
REQ-024 SHALL handle the ERR1/ERR2 states as follows:
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
  - The memory is never written by an error transfer.
REQ-025 SHALL, in the final data-phase cycle (DATA with counter 0, or ERR2), accept a new pipelined address phase, going to DATA or ERR1; otherwise the FSM returns to IDLE.
REQ-026 SHALL compute word index = haddr[log2(DATA_W/8) +: log2(DEPTH)]; higher address bits are ignored, so addresses wrap modulo DEPTH words.
REQ-027 SHALL build byte-lane enables from the registered hsize and low address bits, and on a write update only the enabled lanes from hwdata.
REQ-028 SHALL perform the write at the clock edge ending the final data-phase cycle.
REQ-029 SHALL drive hrdata from the registered word index throughout a read data phase; a read immediately following a write to the same word returns the newly written bytes.
REQ-030 SHALL drive hrdata to 0 outside read data phases and during ERR1/ERR2.
REQ-031 SHALL NOT reset the memory contents, which are undefined until written.

Reset
REQ-032 SHALL, while reset=0, force the following asynchronously:
  - FSM to IDLE;
  - wait counter to 0;
  - hreadyout=1, hresp=0, hrdata=0.
REQ-033 SHALL abandon an in-flight transfer when reset is asserted mid-transfer; a pending write is not performed.
REQ-034 SHALL accept the first address phase on the first rising edge after reset deasserts.

Verification
REQ-035 SHALL be covered by this scenario: DATA_W=32, WAIT_STATES=0; write word 0xDEADBEEF to 0x10, then a back-to-back read of 0x10 -> read returns 0xDEADBEEF, hreadyout never low.
REQ-036 SHALL be covered by this scenario: byte write 0x5A to 0x13 over word 0x11223344 -> read of 0x10 returns 0x5A223344.
REQ-037 SHALL be covered by this scenario: WAIT_STATES=3, single read -> hreadyout low for exactly 3 cycles, then high with data.
REQ-038 SHALL be covered by this scenario: ERR_BASE=0x100, ERR_MASK=0x7F00; write to 0x104 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1); a later read of 0x104 returns the prior contents.
REQ-039 SHALL be covered by this scenario: DATA_W=64, DEPTH=16; halfword read at 0x3 -> two-cycle ERROR; write 0xA5 (byte) to 0x80 -> read of 0x0 shows 0xA5 in byte 0 (wrap).
REQ-040 SHALL be covered by this scenario: reset asserted during WAIT of a write -> outputs return to hreadyout=1, hresp=0, hrdata=0 immediately; the target word is unchanged.

Source files
------------

// File: rtl/ahb_sram_slave_param_if.sv
// AHB-Lite bus bundle between one master and the SRAM slave.
// Widths follow the slave's address and data parameters.
interface ahb_sram_slave_param_if #(
  parameter int ADDR_W = 31,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic              hready;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic              hwrite;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic              hmastlock;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, hready, htrans, hsize, hwrite, haddr, hwdata, hmastlock, hburst, hprot,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, hready, htrans, hsize, hwrite, haddr, hwdata, hmastlock, hburst, hprot,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_slave_param.sv
// AHB-Lite SRAM slave with configurable wait states and an address-decoded error region.
// Misaligned or oversized transfers also complete with the two-cycle ERROR response.
module ahb_sram_slave_param #(
  parameter int              DATA_W      = 32,
  parameter int              ADDR_W      = 31,
  parameter int              DEPTH       = 1024,
  parameter int              WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] ERR_BASE  = '0,
  parameter logic [ADDR_W-1:0] ERR_MASK  = '0
) (
  input logic                    clock,
  input logic                    reset,
  ahb_sram_slave_param_if.slave  io_ahb
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_WAIT = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [2:0]        cnt_r, cnt_s;
  logic [IDX_W-1:0]  idx_r;
  logic [OFF_W-1:0]  off_r;
  logic [2:0]        size_r;
  logic              write_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              take_s;
  logic              err_s;
  logic              we_s;
  logic [BYTES-1:0]  be_s;
  logic              hreadyout_s;
  logic              hresp_s;
  logic [DATA_W-1:0] hrdata_s;
  logic              unused_s;

  // Lanes covered by a 2^size-byte transfer starting at byte offset off.
  function automatic logic [BYTES-1:0] lane_enables(input logic [2:0] size, input logic [OFF_W-1:0] off);
    logic [BYTES-1:0] en;
    int lo;
    int hi;
    en = '0;
    lo = int'(off);
    hi = lo + int'(32'd1 << size);
    for (int i = 0; i < BYTES; i++) begin
      if ((i >= lo) && (i < hi)) begin
        en[i] = 1'b1;
      end else begin
        en[i] = 1'b0;
      end
    end
    return en;
  endfunction

  function automatic logic is_error(input logic [ADDR_W-1:0] addr, input logic [2:0] size);
    logic [ADDR_W-1:0] align_mask;
    logic region;
    logic size_bad;
    logic misaligned;
    region     = (ERR_MASK != '0) && ((addr & ERR_MASK) == ERR_BASE);
    size_bad   = (int'(size) > OFF_W);
    align_mask = (ADDR_W'(1) << size) - ADDR_W'(1);
    misaligned = ((addr & align_mask) != '0);
    return region || size_bad || misaligned;
  endfunction

  assign unused_s = ^{io_ahb.hmastlock, io_ahb.hburst, io_ahb.hprot, io_ahb.htrans[0]};

  // A new address phase is only taken while idle or in the last data-phase cycle.
  assign take_s = io_ahb.hsel && io_ahb.hready && io_ahb.htrans[1] &&
                  ((state_r == ST_IDLE) || (state_r == ST_DATA) || (state_r == ST_ERR2));
  assign err_s  = is_error(io_ahb.haddr, io_ahb.hsize);
  assign we_s   = (state_r == ST_DATA) && write_r;
  assign be_s   = lane_enables(size_r, off_r);

  // State and wait-counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; WAIT counts down to the final DATA cycle.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (take_s) begin
          if (err_s) begin
            state_s = ST_ERR1;
            cnt_s   = 3'd0;
          end else if (WAIT_STATES == 0) begin
            state_s = ST_DATA;
            cnt_s   = 3'd0;
          end else begin
            state_s = ST_WAIT;
            cnt_s   = 3'(WAIT_STATES);
          end
        end else begin
          state_s = ST_IDLE;
          cnt_s   = 3'd0;
        end
      end
      ST_WAIT: begin
        cnt_s = cnt_r - 3'd1;
        if (cnt_r == 3'd1) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_ERR1: begin
        state_s = ST_ERR2;
        cnt_s   = 3'd0;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 3'd0;
      end
    endcase
  end

  // Address-phase capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_r   <= '0;
      off_r   <= '0;
      size_r  <= 3'd0;
      write_r <= 1'b0;
    end else if (take_s) begin
      idx_r   <= io_ahb.haddr[OFF_W +: IDX_W];
      off_r   <= io_ahb.haddr[OFF_W-1:0];
      size_r  <= io_ahb.hsize;
      write_r <= io_ahb.hwrite;
    end
  end

  // Byte-lane write at the edge closing the final data-phase cycle; contents are never reset.
  always_ff @(posedge clock) begin
    if (we_s) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be_s[i]) begin
          mem_r[idx_r][i*8 +: 8] <= io_ahb.hwdata[i*8 +: 8];
        end
      end
    end
  end

  // Response decode from the registered state.
  always_comb begin
    hreadyout_s = 1'b1;
    hresp_s     = 1'b0;
    hrdata_s    = '0;
    case (state_r)
      ST_IDLE: begin
        hreadyout_s = 1'b1;
        hresp_s     = 1'b0;
      end
      ST_DATA: begin
        hreadyout_s = 1'b1;
        hresp_s     = 1'b0;
      end
      ST_WAIT: begin
        hreadyout_s = 1'b0;
        hresp_s     = 1'b0;
      end
      ST_ERR1: begin
        hreadyout_s = 1'b0;
        hresp_s     = 1'b1;
      end
      ST_ERR2: begin
        hreadyout_s = 1'b1;
        hresp_s     = 1'b1;
      end
      default: begin
        hreadyout_s = 1'b1;
        hresp_s     = 1'b0;
      end
    endcase
    if (((state_r == ST_DATA) || (state_r == ST_WAIT)) && !write_r) begin
      hrdata_s = mem_r[idx_r];
    end else begin
      hrdata_s = '0;
    end
  end

  assign io_ahb.hreadyout = hreadyout_s;
  assign io_ahb.hresp     = hresp_s;
  assign io_ahb.hrdata    = hrdata_s;

endmodule
